// File: rtl/fifo_word_packer.sv
// fifo_word_packer: drains bytes from an 8-bit synchronous FIFO and packs
// them little-endian into 32-bit words on a valid/ready output. Partial words
// leave on a flush pulse or, when PACKER_TIMEOUT_EN is defined, after TIMEOUT
// idle cycles. Without PACKER_TIMEOUT_EN no idle counter is built.
module fifo_word_packer #(
  parameter int BYTES_PER_WORD = 4,
  parameter int TIMEOUT        = 16
) (
  input  logic        clock,
  input  logic        reset,
  output logic        rn,
  input  logic [7:0]  data_out,
  input  logic        empty,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [2:0]  out_bytes,
  output logic        busy
);

  localparam logic [2:0] FULL_CNT = 3'(BYTES_PER_WORD);

  // Reject configurations the lane logic was not built for.
  if (BYTES_PER_WORD != 4) begin : g_bad_word_size
    $error("fifo_word_packer: BYTES_PER_WORD must be 4");
  end
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("fifo_word_packer: TIMEOUT must be in 2..255");
  end

  logic [31:0] acc, acc_next;
  logic [2:0]  cnt, cnt_next, cnt_eff;
  logic        pend;
  logic        flush_pend, flush_pend_next;
  logic        flush_req;
  logic        full, flush_xfer, xfer;

  assign full       = (cnt == FULL_CNT);
  assign flush_xfer = flush_pend && !pend && (cnt != 3'd0);
  assign xfer       = (full || flush_xfer) && (!out_valid || out_ready);
  assign cnt_eff    = xfer ? 3'd0 : cnt;

  // A read is only issued when the lane it will land in is guaranteed free,
  // counting the byte already in flight; a transfer this cycle frees all lanes.
  assign rn = !reset && !empty && !flush_pend &&
              (({1'b0, cnt_eff} + {3'b000, pend}) < 4'(BYTES_PER_WORD));

  assign busy = (cnt != 3'd0) || pend || flush_pend || out_valid;

`ifdef PACKER_TIMEOUT_EN
  logic [7:0] idle_cnt;
  logic       timeout_hit;

  assign timeout_hit = (idle_cnt == 8'(TIMEOUT));
  assign flush_req   = flush || timeout_hit;

  // Count cycles where a partial word sits with nothing arriving; a hit acts
  // like a flush pulse and restarts the count so it fires only once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idle_cnt <= 8'd0;
    end else if (pend || xfer || timeout_hit) begin
      idle_cnt <= 8'd0;
    end else if (cnt != 3'd0 && !rn && !flush_pend) begin
      idle_cnt <= idle_cnt + 8'd1;
    end
  end
`else
  assign flush_req = flush;
`endif

  // Next accumulator contents: clear on transfer, then drop the arriving byte
  // into the first free lane (lane 0 if the word just left).
  always_comb begin
    acc_next = xfer ? 32'd0 : acc;
    cnt_next = cnt_eff;
    if (pend) begin
      acc_next[{cnt_eff[1:0], 3'b000} +: 8] = data_out;
      cnt_next = cnt_eff + 3'd1;
    end
  end

  // A pending flush retires once the partial word has moved out, or at once
  // when nothing is held or in flight; a new request always wins.
  always_comb begin
    flush_pend_next = flush_pend;
    if (flush_pend && !pend && (xfer || cnt == 3'd0)) begin
      flush_pend_next = 1'b0;
    end
    if (flush_req) begin
      flush_pend_next = 1'b1;
    end
  end

  // Accumulator, slot count, read-in-flight and flush-request state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc        <= 32'd0;
      cnt        <= 3'd0;
      pend       <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      acc        <= acc_next;
      cnt        <= cnt_next;
      pend       <= rn;
      flush_pend <= flush_pend_next;
    end
  end

  // Output register: load on transfer, otherwise hold until accepted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= 32'd0;
      out_bytes <= 3'd0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= acc;
      out_bytes <= cnt;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// tb_fifo_word_packer: directed bench for fifo_word_packer with a behavioural
// FIFO model and an output-word monitor. Timeout behaviour is checked
// according to whether PACKER_TIMEOUT_EN is defined.
module tb_fifo_word_packer;

  logic        clock = 1'b0;
  logic        reset;
  logic        rn;
  logic [7:0]  data_out;
  logic        empty;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_bytes;
  logic        busy;

  int assertions = 0;
  int failures   = 0;

  logic [7:0]  fifo_mem [0:63];
  int          push_count = 0;
  int          pop_count  = 0;
  logic        read_while_empty = 1'b0;

  logic [31:0] got_data  [0:63];
  logic [2:0]  got_bytes [0:63];
  int          got_wr = 0;
  int          got_rd = 0;

  fifo_word_packer #(.BYTES_PER_WORD(4), .TIMEOUT(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .rn        (rn),
    .data_out  (data_out),
    .empty     (empty),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_bytes (out_bytes),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  assign empty = (push_count == pop_count);

  // FIFO model: read data appears the cycle after rn.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      data_out <= 8'd0;
    end else if (rn) begin
      if (empty) read_while_empty <= 1'b1;
      data_out  <= fifo_mem[pop_count % 64];
      pop_count <= pop_count + 1;
    end
  end

  // Record every accepted output word.
  always @(posedge clock) begin
    if (!reset && out_valid && out_ready) begin
      got_data[got_wr % 64]  <= out_data;
      got_bytes[got_wr % 64] <= out_bytes;
      got_wr <= got_wr + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertions++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    fifo_mem[push_count % 64] = b;
    push_count = push_count + 1;
    @(negedge clock);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic expectWord(input string tag, input logic [31:0] data,
                            input logic [2:0] nbytes, input int budget);
    int waited = 0;
    while (got_wr == got_rd && waited < budget) begin
      @(negedge clock);
      waited++;
    end
    if (got_wr == got_rd) begin
      checkOutput({tag, " word arrived"}, 32'd0, 32'd1);
    end else begin
      checkOutput({tag, " data"}, got_data[got_rd % 64], data);
      checkOutput({tag, " bytes"}, 32'(got_bytes[got_rd % 64]), 32'(nbytes));
      got_rd++;
    end
  endtask

  task automatic pulseFlush();
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;

    // Reset with a byte waiting in the FIFO: no read, nothing valid.
    fifo_mem[0] = 8'h11;
    push_count  = 1;
    waitCycles(2);
    checkOutput("reset rn", 32'(rn), 32'd0);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset out_data", out_data, 32'd0);
    checkOutput("reset out_bytes", 32'(out_bytes), 32'd0);
    reset = 1'b0;

    // Full word.
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    expectWord("full", 32'h44332211, 3'd4, 30);
    waitCycles(3);
    checkOutput("full idle busy", 32'(busy), 32'd0);
    checkOutput("full word count", 32'(got_wr - got_rd), 32'd0);

    // Stall: output blocked, accumulator fills, reads stop.
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) applyStimulus(8'(i));
    waitCycles(20);
    checkOutput("stall out_valid", 32'(out_valid), 32'd1);
    checkOutput("stall out_data", out_data, 32'h04030201);
    checkOutput("stall out_bytes", 32'(out_bytes), 32'd4);
    checkOutput("stall rn", 32'(rn), 32'd0);
    checkOutput("stall busy", 32'(busy), 32'd1);
    waitCycles(5);
    checkOutput("stall hold data", out_data, 32'h04030201);
    checkOutput("stall fifo still holds none", 32'(empty), 32'd1);
    out_ready = 1'b1;
    expectWord("stall w0", 32'h04030201, 3'd4, 10);
    expectWord("stall w1", 32'h08070605, 3'd4, 10);

    // Flush of a two-byte partial word.
    applyStimulus(8'hAA);
    applyStimulus(8'hBB);
    waitCycles(5);
    checkOutput("flush no early word", 32'(got_wr - got_rd), 32'd0);
    pulseFlush();
    expectWord("flush", 32'h0000BBAA, 3'd2, 10);
    waitCycles(3);
    checkOutput("flush after busy", 32'(busy), 32'd0);

    // Flush while idle emits nothing.
    pulseFlush();
    waitCycles(5);
    checkOutput("idle flush no word", 32'(got_wr - got_rd), 32'd0);
    checkOutput("idle flush busy", 32'(busy), 32'd0);

    // Single byte: timeout flush if enabled, otherwise it waits for flush.
    applyStimulus(8'h5C);
`ifdef PACKER_TIMEOUT_EN
    expectWord("timeout", 32'h0000005C, 3'd1, 40);
`else
    waitCycles(100);
    checkOutput("no timeout word", 32'(got_wr - got_rd), 32'd0);
    checkOutput("no timeout busy", 32'(busy), 32'd1);
    pulseFlush();
    expectWord("late flush", 32'h0000005C, 3'd1, 10);
`endif
    waitCycles(3);

    // Reset after three bytes are captured: nothing comes out.
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    applyStimulus(8'h03);
    waitCycles(4);
    checkOutput("pre-reset busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("mid reset busy", 32'(busy), 32'd0);
    checkOutput("mid reset out_valid", 32'(out_valid), 32'd0);
    reset = 1'b0;
    waitCycles(10);
    checkOutput("post reset no word", 32'(got_wr - got_rd), 32'd0);
    applyStimulus(8'hDE);
    applyStimulus(8'hAD);
    applyStimulus(8'hBE);
    applyStimulus(8'hEF);
    expectWord("after reset", 32'hEFBEADDE, 3'd4, 30);

    checkOutput("never read while empty", 32'(read_while_empty), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
